// File: rtl/csa_acc_pkg.sv
// Shared types and constants for the carry-save stream accumulator.
// Imported by the accumulator top and its compressor row.
package csa_acc_pkg;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        OUTPUT  = 2'd2
    } state_e;

    localparam int COUNT_W   = 8;
    localparam int COUNT_MAX = 255;

    // Number of carry-propagate cycles needed to resolve the redundant pair
    function automatic int num_chunks(input int acc_w, input int chunk);
        return acc_w / chunk;
    endfunction

endpackage

// File: rtl/csa_row.sv
// Team full-adder cell and an N-wide row of them forming a 3:2 compressor.
// The row emits unshifted carries; any shift/truncation belongs to the caller.
module csa_full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_sum,
    output logic o_carry
);

    assign o_sum   = i_a ^ i_b ^ i_c;
    assign o_carry = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

module csa_row #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [N-1:0] i_c,
    output logic [N-1:0] o_sum,
    output logic [N-1:0] o_carry
);

    for (genvar g = 0; g < N; g++) begin : g_fa
        csa_full_adder u_fa (
            .i_a    (i_a[g]),
            .i_b    (i_b[g]),
            .i_c    (i_c[g]),
            .o_sum  (o_sum[g]),
            .o_carry(o_carry[g])
        );
    end

endmodule

// File: rtl/csa_stream_accumulator.sv
// Streams operands into a redundant (sum, carry) pair, one compressor row per
// beat, then resolves the pair CHUNK bits per cycle and hands out the result.
module csa_stream_accumulator
    import csa_acc_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 40,
    parameter int CHUNK     = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 op_valid_i,
    output logic                 op_ready_o,
    input  logic [WIDTH-1:0]     op_data_i,
    input  logic                 op_last_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [ACC_WIDTH-1:0] res_data_o,
    output logic [COUNT_W-1:0]   res_count_o,
    output logic                 busy_o
);

    localparam int K     = num_chunks(ACC_WIDTH, CHUNK);
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

    state_e r_state;
    state_e w_state_next;

    logic        [ACC_WIDTH-1:0] r_sum;
    logic        [ACC_WIDTH-1:0] r_carry;
    logic        [ACC_WIDTH-1:0] r_res;
    logic        [COUNT_W-1:0]   r_count;
    logic        [IDX_W-1:0]     r_idx;
    logic                        r_cin;

    logic signed [WIDTH-1:0]     w_op_s;
    logic        [ACC_WIDTH-1:0] w_x;
    logic        [ACC_WIDTH-1:0] w_acc_sum;
    logic        [ACC_WIDTH-1:0] w_acc_cout;
    logic        [ACC_WIDTH-1:0] w_acc_carry;
    logic                        w_accept;
    logic                        w_last_slice;

    logic        [CHUNK-1:0]     w_sum_slice;
    logic        [CHUNK-1:0]     w_carry_slice;
    logic        [CHUNK-1:0]     w_cin_vec;
    logic        [CHUNK-1:0]     w_sl_s;
    logic        [CHUNK-1:0]     w_sl_c;
    logic        [CHUNK:0]       w_sl_total;

    // Signed size cast performs the sign extension to the accumulator width
    assign w_op_s      = op_data_i;
    assign w_x         = ACC_WIDTH'(w_op_s);
    assign w_acc_carry = w_acc_cout << 1;
    assign w_accept    = op_valid_i && (r_state == ACCUM);
    assign w_last_slice = (r_idx == IDX_W'(K - 1));

    csa_row #(.N(ACC_WIDTH)) u_acc_row (
        .i_a    (r_sum),
        .i_b    (r_carry),
        .i_c    (w_x),
        .o_sum  (w_acc_sum),
        .o_carry(w_acc_cout)
    );

    // Slice adder: compress (sum, carry, cin) then add the two vectors; the
    // true slice total never exceeds CHUNK+1 bits, so bit CHUNK is the carry-out
    assign w_sum_slice   = r_sum[r_idx*CHUNK +: CHUNK];
    assign w_carry_slice = r_carry[r_idx*CHUNK +: CHUNK];
    assign w_cin_vec     = CHUNK'(r_cin);

    csa_row #(.N(CHUNK)) u_slice_row (
        .i_a    (w_sum_slice),
        .i_b    (w_carry_slice),
        .i_c    (w_cin_vec),
        .o_sum  (w_sl_s),
        .o_carry(w_sl_c)
    );

    assign w_sl_total = {1'b0, w_sl_s} + {w_sl_c, 1'b0};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ACCUM:   if (op_valid_i && op_last_i) w_state_next = RESOLVE;
            RESOLVE: if (w_last_slice)            w_state_next = OUTPUT;
            OUTPUT:  if (res_ready_i)             w_state_next = ACCUM;
            default:                              w_state_next = ACCUM;
        endcase
    end

    always_comb begin
        op_ready_o  = (r_state == ACCUM);
        res_valid_o = (r_state == OUTPUT);
        busy_o      = (r_state != ACCUM) || (r_count != '0);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_sum   <= '0;
            r_carry <= '0;
            r_res   <= '0;
            r_count <= '0;
            r_idx   <= '0;
            r_cin   <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        r_sum   <= w_acc_sum;
                        r_carry <= w_acc_carry;
                        if (r_count != COUNT_W'(COUNT_MAX)) begin
                            r_count <= r_count + 1'b1;
                        end
                        if (op_last_i) begin
                            r_idx <= '0;
                            r_cin <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    r_res[r_idx*CHUNK +: CHUNK] <= w_sl_total[CHUNK-1:0];
                    if (w_last_slice) begin
                        r_idx <= '0;
                        r_cin <= 1'b0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                        r_cin <= w_sl_total[CHUNK];
                    end
                end
                OUTPUT: begin
                    if (res_ready_i) begin
                        r_sum   <= '0;
                        r_carry <= '0;
                        r_count <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_data_o  = r_res;
    assign res_count_o = r_count;

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Directed bench for csa_stream_accumulator with hand-computed expected results.
module tb_csa_stream_accumulator;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        op_valid_i;
    logic        op_ready_o;
    logic [31:0] op_data_i;
    logic        op_last_i;
    logic        res_valid_o;
    logic        res_ready_i;
    logic [39:0] res_data_o;
    logic [7:0]  res_count_o;
    logic        busy_o;

    int n_chk  = 0;
    int n_pass = 0;

    csa_stream_accumulator #(.WIDTH(32), .ACC_WIDTH(40), .CHUNK(8)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .op_valid_i (op_valid_i),
        .op_ready_o (op_ready_o),
        .op_data_i  (op_data_i),
        .op_last_i  (op_last_i),
        .res_valid_o(res_valid_o),
        .res_ready_i(res_ready_i),
        .res_data_o (res_data_o),
        .res_count_o(res_count_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Presents one operand and returns 1 time unit after the accepting edge
    task automatic send(input logic [31:0] d, input logic l);
        int tmo = 0;
        op_valid_i = 1'b1;
        op_data_i  = d;
        op_last_i  = l;
        while (!op_ready_o && tmo < 100) begin
            tick();
            tmo++;
        end
        if (!op_ready_o) chk("send_timeout", 64'(op_ready_o), 64'd1);
        tick();
        op_valid_i = 1'b0;
        op_last_i  = 1'b0;
        op_data_i  = '0;
    endtask

    task automatic wait_res(input string tag, input logic [39:0] exp_d, input logic [7:0] exp_c);
        int cyc = 0;
        while (!res_valid_o && cyc < 2000) begin
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'd5);
        chk({tag, "_data"}, 64'(res_data_o), 64'(exp_d));
        chk({tag, "_count"}, 64'(res_count_o), 64'(exp_c));
        if (res_ready_i) begin
            tick();
            chk({tag, "_valid_drop"}, 64'(res_valid_o), 64'd0);
            chk({tag, "_ready_back"}, 64'(op_ready_o), 64'd1);
            chk({tag, "_idle"}, 64'(busy_o), 64'd0);
        end
    endtask

    initial begin
        rst_ni      = 1'b0;
        op_valid_i  = 1'b1;
        op_data_i   = 32'd5;
        op_last_i   = 1'b0;
        res_ready_i = 1'b1;

        // Reset with a live operand offered: nothing must be captured
        repeat (2) tick();
        chk("rst_op_ready", 64'(op_ready_o), 64'd1);
        chk("rst_res_valid", 64'(res_valid_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_res_data", 64'(res_data_o), 64'd0);
        chk("rst_res_count", 64'(res_count_o), 64'd0);
        op_valid_i = 1'b0;
        rst_ni     = 1'b1;
        tick();
        chk("post_rst_busy", 64'(busy_o), 64'd0);

        // 5 + 7 + (-3) = 9
        send(32'd5, 1'b0);
        chk("busy_after_first", 64'(busy_o), 64'd1);
        send(32'd7, 1'b0);
        send(32'hFFFF_FFFD, 1'b1);
        chk("resolve_not_ready", 64'(op_ready_o), 64'd0);
        wait_res("sum3", 40'h00_0000_0009, 8'd3);

        // Single negative operand under backpressure
        res_ready_i = 1'b0;
        send(32'h8000_0000, 1'b1);
        wait_res("bp", 40'hFF_8000_0000, 8'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_data", 64'(res_data_o), 64'hFF_8000_0000);
            chk("bp_hold_valid", 64'(res_valid_o), 64'd1);
            chk("bp_op_ready", 64'(op_ready_o), 64'd0);
        end
        res_ready_i = 1'b1;
        tick();
        chk("bp_release_ready", 64'(op_ready_o), 64'd1);
        chk("bp_release_valid", 64'(res_valid_o), 64'd0);

        // 300 * 0x7FFFFFFF = 0x9600000000 - 0x12C, count saturates
        for (int i = 0; i < 299; i++) send(32'h7FFF_FFFF, 1'b0);
        send(32'h7FFF_FFFF, 1'b1);
        wait_res("wrap_sat", 40'h95_FFFF_FED4, 8'd255);

        // Carry rippling into the next chunk, and a full-width wrap to zero
        send(32'h0000_00FF, 1'b0);
        send(32'h0000_0001, 1'b1);
        wait_res("chunk_carry", 40'h00_0000_0100, 8'd2);
        send(32'hFFFF_FFFF, 1'b0);
        send(32'h0000_0001, 1'b1);
        wait_res("wrap_zero", 40'h00_0000_0000, 8'd2);

        // Reset landing in the middle of RESOLVE
        send(32'h0000_0010, 1'b1);
        tick();
        rst_ni = 1'b0;
        tick();
        chk("midrst_op_ready", 64'(op_ready_o), 64'd1);
        chk("midrst_res_valid", 64'(res_valid_o), 64'd0);
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_count", 64'(res_count_o), 64'd0);
        rst_ni = 1'b1;
        send(32'd1, 1'b0);
        send(32'd2, 1'b1);
        wait_res("after_rst", 40'h00_0000_0003, 8'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
